// File: rtl/matrix_stream_writer.sv
// Writes one matrix (3 metadata words + row-major element stream) into a BRAM slot, optionally transposed.
// Latency: each BRAM write is registered one cycle after its issuing state/beat; backpressure via data_ready (DATA only).
module matrix_stream_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_SLOTS  = 8,
  parameter int MAX_DIM    = 32,
  localparam int IDW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [IDW-1:0]        matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [63:0]           matrix_name,
  input  logic                  transpose,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  abort,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  write_aborted,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din
);

  typedef enum logic [3:0] {
    IDLE, CHECK, META0, META1, META2, DATA, INVAL, DONE, ERR
  } state_t;

  state_t                state;
  logic [IDW-1:0]        id_q;
  logic [7:0]            rows_q;
  logic [7:0]            cols_q;
  logic [63:0]           name_q;
  logic                  tr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [7:0]            r_cnt;
  logic [7:0]            c_cnt;
  logic [ADDR_WIDTH-1:0] outer_off;
  logic [ADDR_WIDTH-1:0] inner_off;
  logic [ADDR_WIDTH-1:0] outer_step;
  logic [ADDR_WIDTH-1:0] inner_step;

  logic [15:0]           area;
  logic                  cfg_bad;
  logic                  beat;
  logic                  last_col;
  logic                  last_row;
  logic [ADDR_WIDTH-1:0] elem_addr;

  assign write_ready   = (state == IDLE);
  assign data_ready    = (state == DATA);
  assign write_done    = (state == DONE);
  assign write_error   = (state == ERR);
  assign write_aborted = (state == INVAL);

  assign area     = 16'(rows_q) * 16'(cols_q);
  assign cfg_bad  = (rows_q == 8'd0) || (cols_q == 8'd0) ||
                    ({24'd0, rows_q} > 32'(MAX_DIM)) ||
                    ({24'd0, cols_q} > 32'(MAX_DIM)) ||
                    (32'(id_q) >= 32'(NUM_SLOTS)) ||
                    (({16'd0, area} + 32'd3) > 32'(BLOCK_SIZE));

  assign beat      = data_valid && data_ready;
  assign last_col  = (c_cnt == cols_q - 8'd1);
  assign last_row  = (r_cnt == rows_q - 8'd1);
  // Element address = base + 3 + row offset + column offset; offsets are running sums, not products.
  assign elem_addr = base_q + ADDR_WIDTH'(3) + outer_off + inner_off;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      id_q       <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      name_q     <= '0;
      tr_q       <= 1'b0;
      base_q     <= '0;
      r_cnt      <= '0;
      c_cnt      <= '0;
      outer_off  <= '0;
      inner_off  <= '0;
      outer_step <= '0;
      inner_step <= '0;
      bram_wr_en <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
    end else begin
      bram_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (write_request) begin
            id_q   <= matrix_id;
            rows_q <= actual_rows;
            cols_q <= actual_cols;
            name_q <= matrix_name;
            tr_q   <= transpose;
            state  <= CHECK;
          end
        end
        CHECK: begin
          base_q    <= ADDR_WIDTH'(32'(id_q) * 32'(BLOCK_SIZE));
          r_cnt     <= '0;
          c_cnt     <= '0;
          outer_off <= '0;
          inner_off <= '0;
          // Row-major: next row jumps by cols, next column by 1. Transposed: the reverse.
          outer_step <= tr_q ? ADDR_WIDTH'(1) : ADDR_WIDTH'(cols_q);
          inner_step <= tr_q ? ADDR_WIDTH'(rows_q) : ADDR_WIDTH'(1);
          state      <= cfg_bad ? ERR : META0;
        end
        META0: begin
          if (abort) begin
            state <= INVAL;
          end else begin
            bram_wr_en <= 1'b1;
            bram_addr  <= base_q;
            bram_din   <= DATA_WIDTH'({rows_q, cols_q, 16'd0});
            state      <= META1;
          end
        end
        META1: begin
          if (abort) begin
            state <= INVAL;
          end else begin
            bram_wr_en <= 1'b1;
            bram_addr  <= base_q + ADDR_WIDTH'(1);
            bram_din   <= DATA_WIDTH'(name_q[63:32]);
            state      <= META2;
          end
        end
        META2: begin
          if (abort) begin
            state <= INVAL;
          end else begin
            bram_wr_en <= 1'b1;
            bram_addr  <= base_q + ADDR_WIDTH'(2);
            bram_din   <= DATA_WIDTH'(name_q[31:0]);
            state      <= DATA;
          end
        end
        DATA: begin
          if (abort) begin
            state <= INVAL;
          end else if (beat) begin
            bram_wr_en <= 1'b1;
            bram_addr  <= elem_addr;
            bram_din   <= data_in;
            if (last_col) begin
              c_cnt     <= '0;
              inner_off <= '0;
              r_cnt     <= r_cnt + 8'd1;
              outer_off <= outer_off + outer_step;
              if (last_row) state <= DONE;
            end else begin
              c_cnt     <= c_cnt + 8'd1;
              inner_off <= inner_off + inner_step;
            end
          end
        end
        INVAL: begin
          // Zeroing the header word marks the slot as holding no valid matrix.
          bram_wr_en <= 1'b1;
          bram_addr  <= base_q;
          bram_din   <= '0;
          state      <= IDLE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_writer.sv
// Directed bench for matrix_stream_writer: checks metadata/data addressing, errors, abort and reset.
module tb_matrix_stream_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_request;
  logic        write_ready;
  logic [2:0]  matrix_id;
  logic [7:0]  actual_rows;
  logic [7:0]  actual_cols;
  logic [63:0] matrix_name;
  logic        transpose;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        abort;
  logic        write_done;
  logic        write_error;
  logic        write_aborted;
  logic        bram_wr_en;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;

  matrix_stream_writer dut (
    .clk(clk), .rst_n(rst_n),
    .write_request(write_request), .write_ready(write_ready),
    .matrix_id(matrix_id), .actual_rows(actual_rows), .actual_cols(actual_cols),
    .matrix_name(matrix_name), .transpose(transpose),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .abort(abort),
    .write_done(write_done), .write_error(write_error), .write_aborted(write_aborted),
    .bram_wr_en(bram_wr_en), .bram_addr(bram_addr), .bram_din(bram_din)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          n_done = 0;
  int          n_err = 0;
  int          n_abt = 0;
  int          n_overlap = 0;
  int          done_wr = 0;
  logic [13:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] mem [int];

  always @(negedge clk) begin
    if (bram_wr_en) begin
      wa.push_back(bram_addr);
      wd.push_back(bram_din);
      mem[int'(bram_addr)] = bram_din;
      n_wr++;
    end
    if (write_done) begin
      n_done++;
      done_wr = n_wr;
    end
    if (write_error) n_err++;
    if (write_aborted) n_abt++;
    if (int'(write_done) + int'(write_error) + int'(write_aborted) > 1) n_overlap++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!write_ready && k < 50) begin tick(); k++; end
    chk("idle_reached", write_ready, 1'b1);
    repeat (2) tick();
  endtask

  task automatic cmd(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                     input logic [63:0] nm, input logic tr);
    int k = 0;
    while (!write_ready && k < 50) begin tick(); k++; end
    matrix_id = id; actual_rows = r; actual_cols = c; matrix_name = nm; transpose = tr;
    write_request = 1'b1;
    tick();
    write_request = 1'b0;
    // Later changes must be ignored by the latched command.
    matrix_id = 3'd7; actual_rows = 8'd9; actual_cols = 8'd9; transpose = ~tr;
  endtask

  task automatic beat(input logic [31:0] v, input int gap);
    int k = 0;
    data_valid = 1'b1;
    data_in = v;
    while (!data_ready && k < 50) begin tick(); k++; end
    chk("beat_ready", data_ready, 1'b1);
    tick();
    data_valid = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int w0, d0, e0, a0;
    logic [31:0] exp_d [9];
    logic [31:0] tv [6];
    logic [7:0]  er_r [4];
    logic [7:0]  er_c [4];

    rst_n = 1'b0; write_request = 1'b0; matrix_id = '0; actual_rows = '0; actual_cols = '0;
    matrix_name = '0; transpose = 1'b0; data_in = '0; data_valid = 1'b0; abort = 1'b0;
    repeat (2) tick();
    chk("rst_write_ready", write_ready, 1'b1);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_bram_wr_en", bram_wr_en, 1'b0);
    chk("rst_bram_addr", bram_addr, 14'd0);
    chk("rst_bram_din", bram_din, 32'd0);
    chk("rst_pulses", {write_done, write_error, write_aborted}, 3'b000);
    rst_n = 1'b1;
    tick();

    // Row-major 2x3 into slot 1.
    w0 = n_wr; d0 = n_done;
    cmd(3'd1, 8'd2, 8'd3, "MATRIX_A", 1'b0);
    for (int v = 1; v <= 6; v++) beat(32'(v), 0);
    wait_idle();
    exp_d[0] = 32'h0203_0000; exp_d[1] = 32'h4D41_5452; exp_d[2] = 32'h4958_5F41;
    for (int i = 3; i < 9; i++) exp_d[i] = 32'(i - 2);
    chk("rm_wr_count", n_wr - w0, 9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rm_addr%0d", i), wa[w0 + i], 14'(1152 + i));
      chk($sformatf("rm_data%0d", i), wd[w0 + i], exp_d[i]);
    end
    chk("rm_done", n_done - d0, 1);

    // Transposed 2x3 into slot 0.
    w0 = n_wr;
    cmd(3'd0, 8'd2, 8'd3, "TRANSPOS", 1'b1);
    for (int v = 1; v <= 6; v++) beat(32'(v), 0);
    wait_idle();
    tv[0] = 1; tv[1] = 4; tv[2] = 2; tv[3] = 5; tv[4] = 3; tv[5] = 6;
    chk("tr_wr_count", n_wr - w0, 9);
    chk("tr_hdr", mem[0], 32'h0203_0000);
    for (int i = 0; i < 6; i++) chk($sformatf("tr_mem%0d", i + 3), mem[i + 3], tv[i]);

    // Invalid configurations.
    er_r[0] = 8'd0;  er_c[0] = 8'd3;
    er_r[1] = 8'd2;  er_c[1] = 8'd0;
    er_r[2] = 8'd33; er_c[2] = 8'd1;
    er_r[3] = 8'd1;  er_c[3] = 8'd40;
    for (int i = 0; i < 4; i++) begin
      w0 = n_wr; e0 = n_err; d0 = n_done;
      cmd(3'd4, er_r[i], er_c[i], "BADMATRX", 1'b0);
      wait_idle();
      chk($sformatf("err%0d_pulse", i), n_err - e0, 1);
      chk($sformatf("err%0d_no_writes", i), n_wr - w0, 0);
      chk($sformatf("err%0d_no_done", i), n_done - d0, 0);
    end

    // 3x3 into slot 3 with data_valid low every other cycle.
    w0 = n_wr; d0 = n_done;
    cmd(3'd3, 8'd3, 8'd3, "GAPPYMAT", 1'b0);
    for (int v = 1; v <= 9; v++) beat(32'(v * 16), 1);
    wait_idle();
    chk("gap_wr_count", n_wr - w0, 12);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("gap_addr%0d", i), wa[w0 + 3 + i], 14'(3459 + i));
      chk($sformatf("gap_data%0d", i), wd[w0 + 3 + i], 32'((i + 1) * 16));
    end
    chk("gap_done", n_done - d0, 1);
    chk("gap_done_after_last", done_wr - w0, 12);

    // Abort a 2x2 into slot 2 after two beats; the beat on the abort edge is dropped.
    w0 = n_wr; d0 = n_done; a0 = n_abt;
    cmd(3'd2, 8'd2, 8'd2, "ABORTME!", 1'b0);
    beat(32'd10, 0);
    beat(32'd20, 0);
    data_valid = 1'b1; data_in = 32'd99; abort = 1'b1;
    tick();
    abort = 1'b0; data_valid = 1'b0;
    wait_idle();
    chk("abt_wr_count", n_wr - w0, 6);
    chk("abt_addr3", wa[w0 + 3], 14'd2307);
    chk("abt_data3", wd[w0 + 3], 32'd10);
    chk("abt_addr4", wa[w0 + 4], 14'd2308);
    chk("abt_data4", wd[w0 + 4], 32'd20);
    chk("abt_inval_addr", wa[w0 + 5], 14'd2304);
    chk("abt_inval_data", wd[w0 + 5], 32'd0);
    chk("abt_pulse", n_abt - a0, 1);
    chk("abt_no_done", n_done - d0, 0);

    // Synchronous reset in the middle of DATA.
    cmd(3'd0, 8'd2, 8'd2, "RESETME!", 1'b0);
    beat(32'd7, 0);
    rst_n = 1'b0; data_valid = 1'b1; data_in = 32'd55;
    tick();
    w0 = n_wr;
    chk("mid_rst_write_ready", write_ready, 1'b1);
    chk("mid_rst_data_ready", data_ready, 1'b0);
    chk("mid_rst_bram_wr_en", bram_wr_en, 1'b0);
    chk("mid_rst_bram_addr", bram_addr, 14'd0);
    chk("mid_rst_bram_din", bram_din, 32'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    data_valid = 1'b0;
    chk("post_rst_no_writes", n_wr - w0, 0);
    chk("post_rst_data_ready", data_ready, 1'b0);
    chk("post_rst_hdr_kept", mem[0], 32'h0202_0000);

    chk("pulse_overlap", n_overlap, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
